// File: rtl/i2s_pkg.sv
// i2s_pkg: frame-format and FSM types shared by the I2S receiver, plus the
// word-select expectation rule used to police frame alignment.
package i2s_pkg;

    typedef enum logic {
        MODE_I2S = 1'b0,   // MSB one sclk after the ws edge
        MODE_LJ  = 1'b1    // MSB coincident with the ws edge
    } i2s_mode_e;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ALIGN     = 2'd1,
        LEFT      = 2'd2,
        RIGHT     = 2'd3
    } i2s_state_e;

    localparam int unsigned MAX_SLOT_W = 32;
    localparam int unsigned CNT_W      = $clog2(MAX_SLOT_W);

    // Word-select level the transmitter must present at a slot position.
    // In I2S framing ws changes one bit early, so the last position of a
    // slot already carries the next channel's level.
    function automatic logic expected_ws(input i2s_mode_e mode,
                                         input logic      right_chan,
                                         input logic      last_pos);
        if ((mode == MODE_I2S) && last_pos) begin
            return ~right_chan;
        end
        return right_chan;
    endfunction

endpackage

// File: rtl/i2s_rx_param_edge_sync.sv
// i2s_edge_sync: two-flop synchroniser for one asynchronous bus line with
// single-clk rise and fall pulses derived from the synchronised level.
module i2s_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two synchroniser stages plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2s_rx_param.sv
// i2s_rx_param: I2S / left-justified serial audio receiver. Oversamples the
// bus with clk, tracks slot positions, polices word-select alignment and
// presents each completed stereo frame through a valid/ready handshake.
// Optional build macro I2S_RX_ERR_CNT_EN adds an 8-bit saturating error
// counter output err_cnt (sync errors plus overruns).
module i2s_rx_param
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned SLOT_W = 32,
    parameter i2s_mode_e   MODE   = MODE_I2S
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I2S_sclk,
    input  logic              I2S_ws,
    input  logic              I2S_data,
    output logic [DATA_W-1:0] lft_chnnl,
    output logic [DATA_W-1:0] rght_chnnl,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              sync_err,
    output logic              overrun
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    if (DATA_W > SLOT_W) begin : g_bad_data_w
        $error("i2s_rx_param: DATA_W must not exceed SLOT_W");
    end
    if (SLOT_W > MAX_SLOT_W) begin : g_bad_slot_w
        $error("i2s_rx_param: SLOT_W exceeds MAX_SLOT_W");
    end
    if (DATA_W < 2) begin : g_bad_min_w
        $error("i2s_rx_param: DATA_W too small");
    end

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W:0]   DATA_LIM = (CNT_W + 1)'(DATA_W);

    logic sclk_sync;
    logic sclk_rise;
    logic sclk_fall;
    logic ws_sync;
    logic ws_rise;
    logic ws_fall;

    i2s_edge_sync u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (I2S_sclk),
        .sync_o  (sclk_sync),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    i2s_edge_sync u_ws_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (I2S_ws),
        .sync_o  (ws_sync),
        .rise_o  (ws_rise),
        .fall_o  (ws_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_sync, sclk_fall, ws_rise};

    i2s_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] lsh_q, lsh_d;
    logic [DATA_W-1:0] rsh_q, rsh_d;
    logic [DATA_W-1:0] lft_q, lft_d;
    logic [DATA_W-1:0] rght_q, rght_d;
    logic              vld_q, vld_d;
    logic              serr_q, serr_d;
    logic              ovr_q, ovr_d;
    logic              data_meta_q, data_sync_q;
    logic              load;
    logic              ws_exp;

    // Data line synchroniser, same depth as sclk so samples line up with rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_meta_q <= 1'b0;
            data_sync_q <= 1'b0;
        end else begin
            data_meta_q <= I2S_data;
            data_sync_q <= data_meta_q;
        end
    end

    // Frame FSM state, slot counter, shift registers and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_SYNC;
            cnt_q   <= '0;
            lsh_q   <= '0;
            rsh_q   <= '0;
            lft_q   <= '0;
            rght_q  <= '0;
            vld_q   <= 1'b0;
            serr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lsh_q   <= lsh_d;
            rsh_q   <= rsh_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            vld_q   <= vld_d;
            serr_q  <= serr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: ws-fall alignment, slot bit counting, ws policing, frame hand-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lsh_d   = lsh_q;
        rsh_d   = rsh_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        vld_d   = vld_q;
        serr_d  = 1'b0;
        ovr_d   = 1'b0;
        load    = 1'b0;
        ws_exp  = expected_ws(MODE, state_q == RIGHT, cnt_q == LAST_POS);

        if (vld_q && out_rdy) begin
            vld_d = 1'b0;
        end

        case (state_q)
            WAIT_SYNC: begin
                if (ws_fall) begin
                    cnt_d = '0;
                    if (MODE == MODE_LJ) begin
                        state_d = LEFT;
                        // A coincident sclk rise already carries the MSB.
                        if (sclk_rise) begin
                            lsh_d = {lsh_q[DATA_W-2:0], data_sync_q};
                            cnt_d = CNT_W'(1);
                        end
                    end else if (sclk_rise) begin
                        // The coincident rise is the one ALIGN would discard.
                        state_d = LEFT;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (sclk_rise) begin
                    state_d = LEFT;
                    cnt_d   = '0;
                end
            end

            LEFT, RIGHT: begin
                if (sclk_rise) begin
                    if (ws_sync != ws_exp) begin
                        serr_d  = 1'b1;
                        state_d = WAIT_SYNC;
                        cnt_d   = '0;
                        lsh_d   = '0;
                        rsh_d   = '0;
                    end else begin
                        if ({1'b0, cnt_q} < DATA_LIM) begin
                            if (state_q == LEFT) begin
                                lsh_d = {lsh_q[DATA_W-2:0], data_sync_q};
                            end else begin
                                rsh_d = {rsh_q[DATA_W-2:0], data_sync_q};
                            end
                        end
                        if (cnt_q == LAST_POS) begin
                            cnt_d   = '0;
                            state_d = (state_q == LEFT) ? RIGHT : LEFT;
                            load    = (state_q == RIGHT);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = WAIT_SYNC;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            lft_d  = lsh_q;
            rght_d = rsh_d;
            vld_d  = 1'b1;
            ovr_d  = vld_q && !out_rdy;
        end
    end

    assign lft_chnnl  = lft_q;
    assign rght_chnnl = rght_q;
    assign out_vld    = vld_q;
    assign sync_err   = serr_q;
    assign overrun    = ovr_q;

`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum;

    // Saturating error tally; a coincident sync error and overrun add two.
    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 9'(serr_d) + 9'(ovr_d);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_param.sv
// tb_i2s_rx_param: drives serial frames into an I2S-mode receiver (24/32)
// and a left-justified receiver (16/32) and checks captured words, event
// pulses and handshake behaviour against the words that were transmitted.
`timescale 1ns/1ps
module tb_i2s_rx_param;

    localparam int SLOT = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic ws_a = 1'b0, data_a = 1'b0, ws_b = 1'b0, data_b = 1'b0;
    logic rdy_a = 1'b0, rdy_b = 1'b0;
    logic [23:0] l_a, r_a;
    logic [15:0] l_b, r_b;
    logic vld_a, serr_a, ovr_a, vld_b, serr_b, ovr_b;
`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] ec_a, ec_b;
`endif

    i2s_rx_param #(.DATA_W(24), .SLOT_W(32), .MODE(i2s_pkg::MODE_I2S)) dut_a (
        .clk(clk), .rst_n(rst_n), .I2S_sclk(sclk), .I2S_ws(ws_a), .I2S_data(data_a),
        .lft_chnnl(l_a), .rght_chnnl(r_a), .out_vld(vld_a), .out_rdy(rdy_a),
        .sync_err(serr_a), .overrun(ovr_a)
`ifdef I2S_RX_ERR_CNT_EN
        , .err_cnt(ec_a)
`endif
    );

    i2s_rx_param #(.DATA_W(16), .SLOT_W(32), .MODE(i2s_pkg::MODE_LJ)) dut_b (
        .clk(clk), .rst_n(rst_n), .I2S_sclk(sclk), .I2S_ws(ws_b), .I2S_data(data_b),
        .lft_chnnl(l_b), .rght_chnnl(r_b), .out_vld(vld_b), .out_rdy(rdy_b),
        .sync_err(serr_b), .overrun(ovr_b)
`ifdef I2S_RX_ERR_CNT_EN
        , .err_cnt(ec_b)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit pad_ones = 1'b0;

    // Monitor: accepted frames and event-pulse tallies, sampled mid-cycle.
    logic [63:0] got_a[$];
    logic [63:0] got_b[$];
    int vcyc_a = 0, vcyc_b = 0, serr_n_a = 0, serr_n_b = 0, ovr_n_a = 0, ovr_n_b = 0;

    always @(negedge clk) begin
        if (vld_a === 1'b1) vcyc_a++;
        if (vld_b === 1'b1) vcyc_b++;
        if (serr_a === 1'b1) serr_n_a++;
        if (serr_b === 1'b1) serr_n_b++;
        if (ovr_a === 1'b1) ovr_n_a++;
        if (ovr_b === 1'b1) ovr_n_b++;
        if (vld_a === 1'b1 && rdy_a === 1'b1) got_a.push_back({8'h00, l_a, 8'h00, r_a});
        if (vld_b === 1'b1 && rdy_b === 1'b1) got_b.push_back({16'h0000, l_b, 16'h0000, r_b});
    end

    function automatic int got_n(input bit sel);
        return sel ? got_b.size() : got_a.size();
    endfunction

    function automatic logic [63:0] got_at(input bit sel, input int i);
        if (sel) return (i < got_b.size()) ? got_b[i] : 64'hX;
        return (i < got_a.size()) ? got_a[i] : 64'hX;
    endfunction

    // ---------------- bus driver ----------------
    task automatic send_bit(input bit sel, input logic w, input logic d);
        sclk = 1'b0;
        if (sel) begin ws_b = w; data_b = d; end
        else     begin ws_a = w; data_a = d; end
        repeat (4) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One slot: word MSB-first in the first dw positions, padding after;
    // ws follows the frame-format rule, optionally inverted at tog_pos.
    task automatic send_slot(input bit sel, input bit chan, input logic [31:0] word, input int tog_pos);
        int dw;
        logic w, d;
        dw = sel ? 16 : 24;
        for (int p = 0; p < SLOT; p++) begin
            w = (sel || p < SLOT - 1) ? chan : ~chan;
            if (p == tog_pos) w = ~w;
            if (p < dw) d = word[dw - 1 - p];
            else        d = pad_ones ? 1'b1 : 1'($urandom_range(0, 1));
            send_bit(sel, w, d);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [31:0] l, input logic [31:0] r, input int r_tog);
        send_slot(sel, 1'b0, l, -1);
        send_slot(sel, 1'b1, r, r_tog);
    endtask

    // Idle right-channel bits, then (I2S only) the extra bit before the MSB.
    task automatic preamble(input bit sel);
        send_bit(sel, 1'b1, 1'b0);
        send_bit(sel, 1'b1, 1'b0);
        if (!sel) send_bit(sel, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        sclk = 1'b0; ws_a = 1'b0; data_a = 1'b0; ws_b = 1'b0; data_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_word(input bit sel, input logic [31:0] l, input logic [31:0] r);
        logic [31:0] m;
        m = sel ? 32'h0000FFFF : 32'h00FFFFFF;
        return {l & m, r & m};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (l_a !== 24'h0) begin n_fail++; $display("FAIL reset_l_a: got %h expected 0", l_a); end
        n_cmp++; if (r_a !== 24'h0) begin n_fail++; $display("FAIL reset_r_a: got %h expected 0", r_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_vld_a: got %b expected 0", vld_a); end
        n_cmp++; if (serr_a !== 1'b0 || ovr_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulses_a: got %b%b expected 00", serr_a, ovr_a); end
        n_cmp++; if ({l_b, r_b} !== 32'h0) begin n_fail++; $display("FAIL reset_data_b: got %h expected 0", {l_b, r_b}); end
        n_cmp++; if ({vld_b, serr_b, ovr_b} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl_b: got %b expected 000", {vld_b, serr_b, ovr_b}); end
`ifdef I2S_RX_ERR_CNT_EN
        n_cmp++; if (ec_a !== 8'h0 || ec_b !== 8'h0) begin n_fail++; $display("FAIL reset_err_cnt: got %h/%h expected 0", ec_a, ec_b); end
`endif
        reset_dut();
    endtask

    task automatic test_i2s_basic();
        int gb, vb, sb;
        logic [31:0] l2, r2;
        reset_dut();
        rdy_a = 1'b1;
        gb = got_n(0); vb = vcyc_a; sb = serr_n_a;
        l2 = $urandom; r2 = $urandom;
        preamble(0);
        send_frame(0, 32'hABCDEF, 32'h123456, -1);
        send_frame(0, l2, r2, -1);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (got_n(0) - gb !== 2) begin n_fail++; $display("FAIL i2s_frames: got %0d expected 2", got_n(0) - gb); end
        n_cmp++; if (got_at(0, gb) !== exp_word(0, 32'hABCDEF, 32'h123456)) begin n_fail++; $display("FAIL i2s_frame0: got %h expected %h", got_at(0, gb), exp_word(0, 32'hABCDEF, 32'h123456)); end
        n_cmp++; if (got_at(0, gb + 1) !== exp_word(0, l2, r2)) begin n_fail++; $display("FAIL i2s_frame1: got %h expected %h", got_at(0, gb + 1), exp_word(0, l2, r2)); end
        n_cmp++; if (vcyc_a - vb !== 2) begin n_fail++; $display("FAIL i2s_vld_cycles: got %0d expected 2", vcyc_a - vb); end
        n_cmp++; if (serr_n_a - sb !== 0) begin n_fail++; $display("FAIL i2s_no_sync_err: got %0d expected 0", serr_n_a - sb); end
    endtask

    task automatic test_lj_padding();
        int gb, vb;
        logic [31:0] l2, r2;
        reset_dut();
        rdy_b = 1'b1;
        pad_ones = 1'b1;
        gb = got_n(1); vb = vcyc_b;
        l2 = $urandom; r2 = $urandom;
        preamble(1);
        send_frame(1, 32'h8001, 32'h7FFE, -1);
        send_frame(1, l2, r2, -1);
        repeat (10) @(posedge clk);
        #1;
        pad_ones = 1'b0;
        n_cmp++; if (got_at(1, gb) !== exp_word(1, 32'h8001, 32'h7FFE)) begin n_fail++; $display("FAIL lj_frame0: got %h expected %h", got_at(1, gb), exp_word(1, 32'h8001, 32'h7FFE)); end
        n_cmp++; if (got_at(1, gb + 1) !== exp_word(1, l2, r2)) begin n_fail++; $display("FAIL lj_frame1: got %h expected %h", got_at(1, gb + 1), exp_word(1, l2, r2)); end
        n_cmp++; if (vcyc_b - vb !== 2) begin n_fail++; $display("FAIL lj_vld_cycles: got %0d expected 2", vcyc_b - vb); end
        n_cmp++; if (serr_n_b !== 0) begin n_fail++; $display("FAIL lj_no_sync_err: got %0d expected 0", serr_n_b); end
    endtask

    task automatic test_random_stream(input bit sel, input int nfr);
        logic [63:0] exp_q[$];
        logic [31:0] l, r;
        int gb, ob;
        bit done;
        reset_dut();
        gb = got_n(sel);
        ob = sel ? ovr_n_b : ovr_n_a;
        done = 1'b0;
        fork
            begin
                preamble(sel);
                for (int i = 0; i < nfr; i++) begin
                    l = $urandom; r = $urandom;
                    exp_q.push_back(exp_word(sel, l, r));
                    send_frame(sel, l, r, -1);
                end
                repeat (10) @(posedge clk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (sel) rdy_b = 1'($urandom_range(0, 1));
                    else     rdy_a = 1'($urandom_range(0, 1));
                end
            end
        join
        if (sel) rdy_b = 1'b1; else rdy_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (got_n(sel) - gb !== nfr) begin n_fail++; $display("FAIL rand_count_%0d: got %0d expected %0d", sel, got_n(sel) - gb, nfr); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_at(sel, gb + i) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_frame_%0d_%0d: got %h expected %h", sel, i, got_at(sel, gb + i), exp_q[i]);
            end
        end
        n_cmp++; if ((sel ? ovr_n_b : ovr_n_a) - ob !== 0) begin n_fail++; $display("FAIL rand_no_overrun_%0d: got %0d expected 0", sel, (sel ? ovr_n_b : ovr_n_a) - ob); end
    endtask

    task automatic test_sync_err();
        logic [63:0] exp_q[$];
        logic [31:0] l, r;
        int gb, vb, sb;
        reset_dut();
        rdy_a = 1'b1;
        gb = got_n(0); vb = vcyc_a; sb = serr_n_a;
        preamble(0);
        for (int f = 0; f < 4; f++) begin
            l = $urandom; r = $urandom;
            if (f != 1) exp_q.push_back(exp_word(0, l, r));
            send_frame(0, l, r, (f == 1) ? 20 : -1);
        end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (serr_n_a - sb !== 1) begin n_fail++; $display("FAIL sync_err_pulses: got %0d expected 1", serr_n_a - sb); end
        n_cmp++; if (got_n(0) - gb !== 3) begin n_fail++; $display("FAIL sync_err_frames: got %0d expected 3", got_n(0) - gb); end
        n_cmp++; if (vcyc_a - vb !== 3) begin n_fail++; $display("FAIL sync_err_vld_cycles: got %0d expected 3", vcyc_a - vb); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got_at(0, gb + i) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sync_err_frame_%0d: got %h expected %h", i, got_at(0, gb + i), exp_q[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int gb, ob;
        reset_dut();
        rdy_a = 1'b0;
        gb = got_n(0); ob = ovr_n_a;
        preamble(0);
        send_frame(0, 32'h111111, 32'h222222, -1);
        n_cmp++; if ({vld_a, l_a, r_a} !== {1'b1, 24'h111111, 24'h222222}) begin n_fail++; $display("FAIL ovr_first_frame: got %b %h %h expected 1 111111 222222", vld_a, l_a, r_a); end
        send_frame(0, 32'h333333, 32'h444444, -1);
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (vld_a !== 1'b1) begin n_fail++; $display("FAIL ovr_vld_held: got %b expected 1", vld_a); end
        n_cmp++; if ({l_a, r_a} !== {24'h333333, 24'h444444}) begin n_fail++; $display("FAIL ovr_data: got %h expected 333333444444", {l_a, r_a}); end
        n_cmp++; if (ovr_n_a - ob !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_n_a - ob); end
        n_cmp++; if (got_n(0) - gb !== 0) begin n_fail++; $display("FAIL ovr_no_accept: got %0d expected 0", got_n(0) - gb); end
        rdy_a = 1'b1;
        @(posedge clk);
        #1 rdy_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (got_at(0, gb) !== exp_word(0, 32'h333333, 32'h444444)) begin n_fail++; $display("FAIL ovr_accepted: got %h expected %h", got_at(0, gb), exp_word(0, 32'h333333, 32'h444444)); end
        n_cmp++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL ovr_vld_cleared: got %b expected 0", vld_a); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] l2, l3, r3;
        int gb;
        reset_dut();
        rdy_a = 1'b0;
        l2 = $urandom; l3 = $urandom; r3 = $urandom;
        preamble(0);
        send_frame(0, 32'hA5A5A5, 32'h5A5A5A, -1);
        for (int p = 0; p < 10; p++) send_bit(0, 1'b0, l2[23 - p]);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({l_a, r_a} !== 48'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", {l_a, r_a}); end
        n_cmp++; if ({vld_a, serr_a, ovr_a} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 000", {vld_a, serr_a, ovr_a}); end
        reset_dut();
        rdy_a = 1'b1;
        gb = got_n(0);
        preamble(0);
        send_frame(0, l3, r3, -1);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (got_n(0) - gb !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", got_n(0) - gb); end
        n_cmp++; if (got_at(0, gb) !== exp_word(0, l3, r3)) begin n_fail++; $display("FAIL midrst_frame: got %h expected %h", got_at(0, gb), exp_word(0, l3, r3)); end
    endtask

`ifdef I2S_RX_ERR_CNT_EN
    task automatic test_err_cnt();
        int sb;
        reset_dut();
        rdy_a = 1'b1;
        sb = serr_n_a;
        send_bit(0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            send_bit(0, 1'b0, 1'b0);
            send_bit(0, 1'b1, 1'b0);
            if (i == 99) begin
                n_cmp++; if (ec_a !== 8'd100) begin n_fail++; $display("FAIL err_cnt_100: got %0d expected 100", ec_a); end
            end
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (serr_n_a - sb !== 300) begin n_fail++; $display("FAIL err_cnt_pulses: got %0d expected 300", serr_n_a - sb); end
        n_cmp++; if (ec_a !== 8'd255) begin n_fail++; $display("FAIL err_cnt_sat: got %0d expected 255", ec_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_i2s_basic();
        test_lj_padding();
        test_random_stream(1'b0, 6);
        test_random_stream(1'b1, 6);
        test_sync_err();
        test_overrun();
        test_reset_midframe();
`ifdef I2S_RX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
